// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control with memory-wait FSM and timeout; define HAZARD_PERF_EN for perf counters
module hazard_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  rd_e,
  input  logic [4:0]  rd_m,
  input  logic [4:0]  rd_w,
  input  logic        reg_write_m,
  input  logic        reg_write_w,
  input  logic        load_e,
  input  logic        pc_src_e,
  input  logic        mem_req_m,
  input  logic        mem_ready,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_w,
  output logic [1:0]  forward_a_e,
  output logic [1:0]  forward_b_e,
  output logic        mem_busy,
  output logic        mem_timeout,
  output logic [31:0] load_use_cnt,
  output logic [31:0] mem_wait_cnt,
  output logic [31:0] flush_cnt
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX = CW'(MAX_WAIT);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [CW-1:0] wait_cnt, cnt_nxt;
  logic lu, mw;
  function automatic logic [1:0] fwd(input logic [4:0] x);
    return (reg_write_m && rd_m != 5'd0 && rd_m == x) ? 2'b10 :
           (reg_write_w && rd_w != 5'd0 && rd_w == x) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    lu = load_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    mw = mem_req_m && !mem_ready;
    stall_f = rst && (mw || (lu && !pc_src_e));
    stall_d = stall_f;
    stall_e = rst && mw;
    stall_m = stall_e;
    flush_w = !rst || mw;
    flush_d = !rst || (!mw && pc_src_e);
    flush_e = !rst || (!mw && (pc_src_e || lu));
    forward_a_e = rst ? fwd(rs1_e) : 2'b00;
    forward_b_e = rst ? fwd(rs2_e) : 2'b00;
    mem_busy = state == WAIT;
    cnt_nxt = state != WAIT ? '0 : (!mem_ready && wait_cnt != MAX) ? wait_cnt + CW'(1) : wait_cnt;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= mw ? WAIT : IDLE;
      wait_cnt <= cnt_nxt;
      mem_timeout <= mem_timeout || cnt_nxt == MAX;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_use_cnt <= '0;
      mem_wait_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      load_use_cnt <= load_use_cnt + 32'(lu && !mw && !pc_src_e);
      mem_wait_cnt <= mem_wait_cnt + 32'(mw);
      flush_cnt <= flush_cnt + 32'(pc_src_e && !mw);
    end
  end
`else
  assign load_use_cnt = '0;
  assign mem_wait_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed check of hazard_ctrl against a rule-level reference model
module tb_hazard_ctrl;
  localparam int MAXW = 4;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic reg_write_m, reg_write_w, load_e, pc_src_e, mem_req_m, mem_ready;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0] forward_a_e, forward_b_e;
  logic mem_busy, mem_timeout;
  logic [31:0] load_use_cnt, mem_wait_cnt, flush_cnt;
  int n_cmp = 0;
  int n_err = 0;
  bit m_busy, m_to;
  int m_cnt;
  logic [31:0] m_lu_cnt, m_mw_cnt, m_fl_cnt;
  hazard_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .load_e(load_e), .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mem_busy(mem_busy), .mem_timeout(mem_timeout),
    .load_use_cnt(load_use_cnt), .mem_wait_cnt(mem_wait_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic bit lu_ref();
    return load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
  endfunction
  function automatic logic [1:0] fwd_ref(input logic [4:0] x);
    if (!rst) return 2'b00;
    if (reg_write_m && rd_m != 0 && rd_m == x) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == x) return 2'b01;
    return 2'b00;
  endfunction
  task automatic check_all();
    bit mwv, sf, sd, se, sm, fd, fe, fw;
    mwv = mem_req_m && !mem_ready;
    {sf, sd, se, sm, fd, fe, fw} = '0;
    if (!rst) {fd, fe, fw} = 3'b111;
    else if (mwv) {sf, sd, se, sm, fw} = 5'b11111;
    else if (pc_src_e) {fd, fe} = 2'b11;
    else if (lu_ref()) {sf, sd, fe} = 3'b111;
    check("stall_f", 32'(stall_f), 32'(sf));
    check("stall_d", 32'(stall_d), 32'(sd));
    check("stall_e", 32'(stall_e), 32'(se));
    check("stall_m", 32'(stall_m), 32'(sm));
    check("flush_d", 32'(flush_d), 32'(fd));
    check("flush_e", 32'(flush_e), 32'(fe));
    check("flush_w", 32'(flush_w), 32'(fw));
    check("fwd_a", 32'(forward_a_e), 32'(fwd_ref(rs1_e)));
    check("fwd_b", 32'(forward_b_e), 32'(fwd_ref(rs2_e)));
    check("mem_busy", 32'(mem_busy), 32'(m_busy));
    check("mem_timeout", 32'(mem_timeout), 32'(m_to));
`ifdef HAZARD_PERF_EN
    check("load_use_cnt", load_use_cnt, m_lu_cnt);
    check("mem_wait_cnt", mem_wait_cnt, m_mw_cnt);
    check("flush_cnt", flush_cnt, m_fl_cnt);
`else
    check("load_use_cnt", load_use_cnt, 32'd0);
    check("mem_wait_cnt", mem_wait_cnt, 32'd0);
    check("flush_cnt", flush_cnt, 32'd0);
`endif
  endtask
  task automatic settle();
    #2;
    check_all();
  endtask
  task automatic tick();
    bit mwv, luv;
    @(posedge clk);
    mwv = mem_req_m && !mem_ready;
    luv = lu_ref();
    if (!rst) begin
      m_busy = 0; m_to = 0; m_cnt = 0;
      m_lu_cnt = 0; m_mw_cnt = 0; m_fl_cnt = 0;
    end else begin
      if (!m_busy) m_cnt = 0;
      else if (!mem_ready && m_cnt < MAXW) m_cnt++;
      if (m_cnt == MAXW) m_to = 1;
      if (luv && !mwv && !pc_src_e) m_lu_cnt++;
      if (mwv) m_mw_cnt++;
      if (pc_src_e && !mwv) m_fl_cnt++;
      m_busy = mwv;
    end
    #1;
  endtask
  task automatic clear_inputs();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {reg_write_m, reg_write_w, load_e, pc_src_e, mem_req_m, mem_ready} = '0;
  endtask
  initial begin
    m_busy = 0; m_to = 0; m_cnt = 0;
    m_lu_cnt = 0; m_mw_cnt = 0; m_fl_cnt = 0;
    rst = 1'b0;
    clear_inputs();
    tick();
    settle();
    check("rst_flush_d", 32'(flush_d), 32'd1);
    check("rst_mem_busy", 32'(mem_busy), 32'd0);
    tick();
    rst = 1'b1;
    reg_write_m = 1; rd_m = 5; rs1_e = 5; reg_write_w = 1; rd_w = 6; rs2_e = 6;
    settle();
    check("fwd_m", 32'(forward_a_e), 32'd2);
    check("fwd_w", 32'(forward_b_e), 32'd1);
    tick();
    rd_m = 0; rd_w = 0; rs1_e = 0; rs2_e = 0;
    settle();
    check("fwd_x0", 32'({forward_a_e, forward_b_e}), 32'd0);
    tick();
    clear_inputs();
    load_e = 1; rd_e = 7; rs2_d = 7;
    settle();
    check("lu_stall", 32'({stall_f, stall_d, flush_e}), 32'd7);
    tick();
    load_e = 0;
    settle();
    check("lu_once", 32'({stall_f, stall_d, flush_e}), 32'd0);
    tick();
    load_e = 1; pc_src_e = 1;
    settle();
    check("lu_br", 32'({stall_f, stall_d, flush_d, flush_e}), 32'b0011);
    tick();
    clear_inputs();
    mem_req_m = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("mw_stall", 32'({stall_f, stall_e, stall_m, flush_w}), 32'hf);
      tick();
    end
    mem_ready = 1;
    settle();
    check("mw_release", 32'({stall_f, stall_e, flush_w}), 32'd0);
    tick();
    clear_inputs();
    settle();
    check("mw_idle", 32'(mem_busy), 32'd0);
    tick();
    mem_req_m = 1;
    for (int i = 0; i < 6; i++) begin
      settle();
      tick();
    end
    mem_ready = 1;
    settle();
    check("timeout_set", 32'(mem_timeout), 32'd1);
    tick();
    clear_inputs();
    settle();
    check("timeout_sticky", 32'(mem_timeout), 32'd1);
    tick();
    mem_req_m = 1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("rst_wait_flush", 32'({flush_d, flush_e, flush_w, stall_f}), 32'b1110);
    tick();
    settle();
    check("rst_wait_busy", 32'({mem_busy, mem_timeout}), 32'd0);
    tick();
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 79) != 0;
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3));
      rd_w = 5'($urandom_range(0, 3));
      reg_write_m = 1'($urandom_range(0, 1)); reg_write_w = 1'($urandom_range(0, 1));
      load_e = 1'($urandom_range(0, 1)); pc_src_e = $urandom_range(0, 3) == 0;
      mem_req_m = $urandom_range(0, 3) != 0; mem_ready = $urandom_range(0, 3) == 0;
      settle();
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
